// File: rtl/ddfs_note_seq.sv
// Note sequencer for the DDFS audio core: a FIFO of queued notes played
// back-to-back with a linear attack/sustain/release amplitude envelope.
module ddfs_note_seq #(
   parameter int PW       = 30,
   parameter int DEPTH    = 16,
   parameter int TICK_DIV = 100000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [4:0]    addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data,
   output logic [PW-1:0] fccw_out,
   output logic [2:0]    wave_sel,
   output logic [15:0]   env_out,
   output logic          busy,
   output logic          note_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TICK_DIV + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, ATTACK, SUSTAIN, RELEASE
   } state_t;

   typedef struct packed {
      logic [PW-1:0] fccw;
      logic [2:0]    wave;
      logic [15:0]   dur;
   } note_t;

   state_t        state, state_nxt;
   note_t         mem [DEPTH];
   note_t         head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          empty, full;
   logic [PW-1:0] stage;
   logic [15:0]   step, peak, dur_cnt;
   logic [TW-1:0] psc, psc_nxt;
   logic          run, ovf;
   logic          wr_en, wr_stage, push, wr_ctrl, wr_shape;
   logic          flush, clr_ovf, pop, push_ok;
   logic          active, tick, dur_last;
   logic [16:0]   sum;
   logic [15:0]   env_up, env_dn;
   logic          unused;

   assign unused   = ^{read, addr[4:2]};

   assign wr_en    = cs & write;
   assign wr_stage = wr_en & (addr[1:0] == 2'd0);
   assign push     = wr_en & (addr[1:0] == 2'd1);
   assign wr_ctrl  = wr_en & (addr[1:0] == 2'd2);
   assign wr_shape = wr_en & (addr[1:0] == 2'd3);
   assign flush    = wr_ctrl & wr_data[1];
   assign clr_ovf  = wr_ctrl & wr_data[2];

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign pop      = (state == LOAD);
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign push_ok  = push & (~full | pop) & ~flush;
   assign head     = mem[rd_ptr];

   assign active   = (state == ATTACK) | (state == SUSTAIN) | (state == RELEASE);
   assign tick     = active & (psc == TW'(TICK_DIV - 1));
   assign psc_nxt  = tick ? '0 : psc + TW'(1);
   assign dur_last = (dur_cnt <= 16'd1);

   // step==0 saturates immediately in both directions so a note always ends
   assign sum      = {1'b0, env_out} + {1'b0, step};
   assign env_up   = (step == 16'd0 || sum >= {1'b0, peak}) ? peak : sum[15:0];
   assign env_dn   = (step == 16'd0 || env_out <= step) ? 16'd0 : env_out - step;

   assign busy     = (state != IDLE);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (run && !empty) state_nxt = LOAD;
            LOAD:    state_nxt = ATTACK;
            ATTACK:  if (tick) begin
                        if (dur_last)          state_nxt = RELEASE;
                        else if (env_up == peak) state_nxt = SUSTAIN;
                     end
            SUSTAIN: if (tick && dur_last) state_nxt = RELEASE;
            RELEASE: if (tick && env_dn == 16'd0)
                        state_nxt = (run && !empty) ? LOAD : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // note storage, written only when the push is accepted
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {stage, wr_data[18:0]};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // software-visible registers and sticky overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage <= '0;
         step  <= 16'h0100;
         peak  <= 16'h4000;
         run   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (wr_stage) stage <= wr_data[PW-1:0];
         if (wr_ctrl)  run   <= wr_data[0];
         if (wr_shape) begin
            step <= wr_data[15:0];
            peak <= wr_data[31:16];
         end
         if (clr_ovf)                ovf <= 1'b0;
         else if (push && !push_ok)  ovf <= 1'b1;
      end
   end

   // note playback: load outputs, prescaler, envelope and duration
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fccw_out  <= '0;
         wave_sel  <= '0;
         env_out   <= '0;
         dur_cnt   <= '0;
         psc       <= '0;
         note_done <= 1'b0;
      end else begin
         note_done <= 1'b0;
         if (flush) begin
            env_out <= '0;
            psc     <= '0;
         end else begin
            unique case (state)
               LOAD: begin
                  fccw_out <= head.fccw;
                  wave_sel <= head.wave;
                  dur_cnt  <= (head.dur == 16'd0) ? 16'd1 : head.dur;
                  psc      <= '0;
               end
               ATTACK: begin
                  psc <= psc_nxt;
                  if (tick) begin
                     env_out <= env_up;
                     dur_cnt <= dur_cnt - 16'd1;
                  end
               end
               SUSTAIN: begin
                  psc <= psc_nxt;
                  if (tick) begin
                     env_out <= peak;
                     dur_cnt <= dur_cnt - 16'd1;
                  end
               end
               RELEASE: begin
                  psc <= psc_nxt;
                  if (tick) begin
                     env_out <= env_dn;
                     if (env_dn == 16'd0) note_done <= 1'b1;
                  end
               end
               default: psc <= '0;
            endcase
         end
      end
   end

   // register read mux
   always_comb begin
      rd_data = '0;
      case (addr[1:0])
         2'd0:    rd_data = {16'b0, 8'(count), 4'b0, ovf, full, empty, busy};
         2'd3:    rd_data = {peak, step};
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_ddfs_note_seq.sv
// Randomized bench for ddfs_note_seq: per-cycle envelope trace predicted
// from note durations and shape, plus status checks for FIFO corner cases.
module tb_ddfs_note_seq;

   localparam int TD = 4;

   typedef struct {
      logic [29:0] f;
      logic [2:0]  w;
      logic [15:0] d;
   } note_s;

   typedef struct {
      logic [15:0] env;
      logic        done;
      logic        busy;
      logic [29:0] f;
      logic [2:0]  w;
   } exp_s;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, read, write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [29:0] fccw_out;
   logic [2:0]  wave_sel;
   logic [15:0] env_out;
   logic        busy, note_done;

   int          vectors = 0;
   int          miscompares = 0;
   exp_s        exp_q[$];
   logic [29:0] cur_f = '0;
   logic [2:0]  cur_w = '0;
   int          m_step, m_peak;

   ddfs_note_seq #(.PW(30), .DEPTH(16), .TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .fccw_out(fccw_out), .wave_sel(wave_sel), .env_out(env_out),
      .busy(busy), .note_done(note_done)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; write = 1'b1; addr = {3'b0, a}; wr_data = d;
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      cs = 1'b1; read = 1'b1; addr = {3'b0, a};
      #1 d = rd_data;
      cs = 1'b0; read = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic [31:0] want);
      logic [31:0] s;
      rd(2'd0, s);
      vectors++;
      if (s !== want) begin
         miscompares++;
         $display("FAIL %s status: got %h required %h", tag, s, want);
      end
   endtask

   task automatic set_shape(input int st, input int pk);
      m_step = st; m_peak = pk;
      wr(2'd3, {pk[15:0], st[15:0]});
   endtask

   task automatic push_note(input note_s n);
      wr(2'd0, {2'b0, n.f});
      wr(2'd1, {13'b0, n.w, n.d});
   endtask

   function automatic note_s rnd_note(input int dmax);
      note_s n;
      n.f = 30'($urandom);
      n.w = 3'($urandom);
      n.d = 16'($urandom_range(dmax, 0));
      return n;
   endfunction

   // Expected per-edge outputs starting at the edge after run rises.
   // Envelope after tick k: rises by step (clamped at peak) for the
   // first max(dur,1) ticks, then falls by step until it hits zero.
   task automatic model_notes(input note_s notes[$]);
      exp_s x;
      int   d, e;
      bit   last;
      exp_q.delete();
      x.env = 0; x.done = 0; x.busy = 1; x.f = cur_f; x.w = cur_w;
      exp_q.push_back(x);
      foreach (notes[i]) begin
         d = (notes[i].d == 0) ? 1 : int'(notes[i].d);
         e = 0;
         cur_f = notes[i].f; cur_w = notes[i].w;
         x.env = 0; x.done = 0; x.busy = 1; x.f = cur_f; x.w = cur_w;
         exp_q.push_back(x);
         for (int k = 1; k < 1000; k++) begin
            x.env = 16'(e); x.done = 0; x.busy = 1;
            repeat (TD - 1) exp_q.push_back(x);
            if (k <= d)
               e = (m_step == 0 || e + m_step > m_peak) ? m_peak : e + m_step;
            else
               e = (m_step == 0 || e <= m_step) ? 0 : e - m_step;
            last = (k > d) && (e == 0);
            x.env = 16'(e); x.done = last;
            x.busy = last ? (i < notes.size() - 1) : 1'b1;
            exp_q.push_back(x);
            if (last) break;
         end
      end
   endtask

   task automatic check_trace(input string tag, input int clr_run_at);
      exp_s x;
      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge clk);
         cs = 1'b0; write = 1'b0;
         x = exp_q[c];
         vectors++;
         if ({env_out, note_done, busy, fccw_out, wave_sel} !==
             {x.env, x.done, x.busy, x.f, x.w}) begin
            miscompares++;
            $display("FAIL %s cycle %0d: env=%h done=%b busy=%b fccw=%h wave=%0d required env=%h done=%b busy=%b fccw=%h wave=%0d",
                     tag, c, env_out, note_done, busy, fccw_out, wave_sel,
                     x.env, x.done, x.busy, x.f, x.w);
         end
         if (c == clr_run_at) begin
            cs = 1'b1; write = 1'b1; addr = 5'd2; wr_data = 32'd0;
         end
      end
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic play(input string tag, input note_s notes[$]);
      foreach (notes[i]) push_note(notes[i]);
      model_notes(notes);
      wr(2'd2, 32'd1);
      check_trace(tag, -1);
      wr(2'd2, 32'd0);
      check_status(tag, 32'h2);
   endtask

   task automatic test_reset;
      logic [31:0] s;
      reset = 1'b1; cs = 0; read = 0; write = 0; addr = 0; wr_data = 0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({fccw_out, wave_sel, env_out, busy, note_done} !== '0) begin
         miscompares++;
         $display("FAIL reset outputs: got %h/%h/%h/%b/%b required 0",
                  fccw_out, wave_sel, env_out, busy, note_done);
      end
      reset = 1'b0;
      @(negedge clk);
      check_status("reset", 32'h2);
      rd(2'd3, s);
      vectors++;
      if (s !== 32'h4000_0100) begin
         miscompares++;
         $display("FAIL reset shape: got %h required 40000100", s);
      end
   endtask

   task automatic test_single;
      note_s n[$];
      note_s a;
      set_shape(16'h1000, 16'h4000);
      a.f = 30'h100; a.w = 3'd2; a.d = 16'd10;
      n.push_back(a);
      play("single", n);
   endtask

   task automatic test_back_to_back;
      note_s n[$];
      set_shape($urandom_range(16'h2000, 16'h0400),
                $urandom_range(16'h4000, 16'h0800));
      repeat (3) n.push_back(rnd_note(6));
      play("back_to_back", n);
   endtask

   task automatic test_random;
      note_s n[$];
      for (int b = 0; b < 4; b++) begin
         n.delete();
         set_shape(($urandom_range(4, 0) == 0) ? 0 :
                   $urandom_range(16'h2000, 16'h0400),
                   $urandom_range(16'h4000, 16'h0800));
         repeat ($urandom_range(3, 1)) n.push_back(rnd_note(8));
         play("random", n);
      end
   endtask

   task automatic test_step_zero;
      note_s n[$];
      note_s a;
      set_shape(0, $urandom_range(16'h4000, 16'h0800));
      a = rnd_note(0);
      n.push_back(a);
      play("step_zero", n);
   endtask

   task automatic test_run_clear;
      note_s n[$];
      note_s a, b;
      set_shape(16'h0800, 16'h2000);
      a = rnd_note(4); b = rnd_note(4);
      push_note(a); push_note(b);
      n.push_back(a);
      model_notes(n);
      wr(2'd2, 32'd1);
      check_trace("run_clear", 3);
      check_status("run_clear", 32'h0000_0100);
      wr(2'd2, 32'd2);
      check_status("run_clear_flush", 32'h2);
   endtask

   task automatic test_flush;
      note_s a, b;
      set_shape(16'h4000, 16'h4000);
      a = rnd_note(0); a.d = 16'd20;
      b = rnd_note(4);
      push_note(a); push_note(b);
      wr(2'd2, 32'd1);
      repeat (12) @(negedge clk);
      vectors++;
      if ({env_out, busy} !== {16'h4000, 1'b1}) begin
         miscompares++;
         $display("FAIL flush sustain: env=%h busy=%b required 4000/1",
                  env_out, busy);
      end
      wr(2'd2, 32'd3);
      vectors++;
      if ({env_out, busy, fccw_out, wave_sel} !== {16'h0, 1'b0, a.f, a.w}) begin
         miscompares++;
         $display("FAIL flush after: env=%h busy=%b fccw=%h wave=%0d required 0/0/%h/%0d",
                  env_out, busy, fccw_out, wave_sel, a.f, a.w);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         vectors++;
         if ({note_done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush quiet cycle %0d: done=%b busy=%b required 0/0",
                     c, note_done, busy);
         end
      end
      check_status("flush", 32'h2);
      wr(2'd2, 32'd0);
      cur_f = a.f; cur_w = a.w;
   endtask

   task automatic test_overflow;
      repeat (17) push_note(rnd_note(8));
      check_status("overflow", 32'h0000_100C);
      wr(2'd2, 32'd4);
      check_status("overflow_clear", 32'h0000_1004);
      wr(2'd2, 32'd2);
      check_status("overflow_flush", 32'h2);
   endtask

   task automatic test_reset_mid;
      logic [31:0] s;
      note_s a;
      set_shape(16'h1000, 16'h4000);
      a = rnd_note(0); a.d = 16'd10;
      push_note(a); push_note(rnd_note(4));
      wr(2'd2, 32'd1);
      repeat (7) @(negedge clk);
      vectors++;
      if ({env_out, fccw_out} !== {16'h1000, a.f}) begin
         miscompares++;
         $display("FAIL mid attack: env=%h fccw=%h required 1000/%h",
                  env_out, fccw_out, a.f);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({fccw_out, wave_sel, env_out, busy, note_done} !== '0) begin
         miscompares++;
         $display("FAIL async reset outputs: got %h/%h/%h/%b/%b required 0",
                  fccw_out, wave_sel, env_out, busy, note_done);
      end
      check_status("reset_during", 32'h2);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_status("reset_after", 32'h2);
      rd(2'd3, s);
      vectors++;
      if (s !== 32'h4000_0100) begin
         miscompares++;
         $display("FAIL reset_after shape: got %h required 40000100", s);
      end
      cur_f = '0; cur_w = '0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_random;
      test_step_zero;
      test_run_clear;
      test_flush;
      test_overflow;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
